// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared constants and types for the video timing generator.
//   - 640x480@60 default timing constants (pixels / lines)
//   - coord_t      : 10-bit pixel column / line coordinate
//   - video_sync_t : registered sync/strobe bundle
//   - in_window()  : half-open range test [lo, hi)
// -----------------------------------------------------------------------------
package video_timing_pkg;

  localparam int   H_ACTIVE_DEF = 640;
  localparam int   H_FP_DEF     = 16;
  localparam int   H_SYNC_DEF   = 96;
  localparam int   H_BP_DEF     = 48;
  localparam int   V_ACTIVE_DEF = 480;
  localparam int   V_FP_DEF     = 10;
  localparam int   V_SYNC_DEF   = 2;
  localparam int   V_BP_DEF     = 33;
  localparam logic SYNC_POL_DEF = 1'b0;

  // Largest total a 10-bit coordinate can count through.
  localparam int   MAX_TOTAL    = 1024;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } video_sync_t;

  // True when v lies in the half-open window [lo, hi).
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-MAX counter that steps on inc_i and wraps MAX-1 -> 0.
// Ports:
//   clk_i   : system clock
//   reset_i : synchronous active-high reset (clears count)
//   inc_i   : advance by one this cycle
//   cnt_o   : current count, 0..MAX-1
//   wrap_o  : combinational, high when this cycle's increment wraps to 0
// -----------------------------------------------------------------------------
module wrap_counter
  import video_timing_pkg::*;
#(
  parameter int MAX = 800
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       inc_i,
  output logic [9:0] cnt_o,
  output logic       wrap_o
);

  localparam coord_t LAST = coord_t'(MAX - 1);

  coord_t cnt_q;
  coord_t cnt_d;

  assign wrap_o = inc_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: hold, step, or wrap back to zero after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (!inc_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d = 10'd0;
    end else begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 10'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator: horizontal/vertical counters plus registered sync,
// data-enable and start strobes. Outputs reflect the counter position held
// before each enabled edge, so they lag the counters by one enabled cycle.
//
// Build option: define VIDEO_TIMING_FRAME_COUNT_EN to build the 16-bit frame
// counter; otherwise frame_count_o is tied to zero.
//
// Ports:
//   clk_i         : system clock
//   reset_i       : synchronous active-high reset (priority over pix_ce_i)
//   pix_ce_i      : pixel enable, one pixel per high cycle
//   screen_x_o    : current column (including blanking)
//   screen_y_o    : current line (including blanking)
//   hsync_o       : horizontal sync, active level SYNC_POL
//   vsync_o       : vertical sync, active level SYNC_POL, per-pixel evaluated
//   de_o          : active-video data enable
//   line_start_o  : one-cycle strobe for column 0
//   frame_start_o : one-cycle strobe for (0,0)
//   frame_count_o : completed-frame count (zero when not built)
// -----------------------------------------------------------------------------
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pix_ce_i,
  output logic [9:0]  screen_x_o,
  output logic [9:0]  screen_y_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic [15:0] frame_count_o
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam video_sync_t SYNC_RST = '{
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    de:          1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_total_too_big
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t      h_cnt;
  coord_t      v_cnt;
  logic        h_wrap;
  logic        v_wrap;

  coord_t      x_q;
  coord_t      y_q;
  video_sync_t sync_q;
  video_sync_t sync_d;

  wrap_counter #(.MAX(H_TOTAL)) u_h_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (pix_ce_i),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap)
  );

  // The line counter steps only when the pixel counter wraps (already gated by pix_ce_i).
  wrap_counter #(.MAX(V_TOTAL)) u_v_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (h_wrap),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap)
  );

  // Decode sync, enable and strobes from the pre-increment counter position.
  always_comb begin
    sync_d             = SYNC_RST;
    sync_d.hsync       = in_window(int'(h_cnt), H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_d.vsync       = in_window(int'(v_cnt), V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_d.de          = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    sync_d.line_start  = (h_cnt == 10'd0);
    sync_d.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Output registers: load on enabled edges; strobes drop on any other cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      sync_q <= SYNC_RST;
    end else if (pix_ce_i) begin
      x_q    <= h_cnt;
      y_q    <= v_cnt;
      sync_q <= sync_d;
    end else begin
      sync_q.line_start  <= 1'b0;
      sync_q.frame_start <= 1'b0;
    end
  end

  assign screen_x_o    = x_q;
  assign screen_y_o    = y_q;
  assign hsync_o       = sync_q.hsync;
  assign vsync_o       = sync_q.vsync;
  assign de_o          = sync_q.de;
  assign line_start_o  = sync_q.line_start;
  assign frame_start_o = sync_q.frame_start;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  // v_wrap marks the enabled edge leaving the last pixel of the frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register, wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count_o = frame_cnt_q;
`else
  logic frame_done_unused;
  assign frame_done_unused = v_wrap;
  assign frame_count_o     = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on a reduced raster so whole frames fit in a short run:
//   H: active 16, fp 2, sync 4, bp 3  -> total 25, hsync at x 18..21
//   V: active 8,  fp 2, sync 2, bp 3  -> total 15, vsync at y 10..11 (50 pixels)
//   one frame = 375 enabled cycles
module tb_video_timing_gen;

  logic        clk_i;
  logic        reset_i;
  logic        pix_ce_i;
  logic [9:0]  screen_x_o;
  logic [9:0]  screen_y_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        line_start_o;
  logic        frame_start_o;
  logic [15:0] frame_count_o;

  int total;
  int bad;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  video_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .pix_ce_i      (pix_ce_i),
    .screen_x_o    (screen_x_o),
    .screen_y_o    (screen_y_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o),
    .line_start_o  (line_start_o),
    .frame_start_o (frame_start_o),
    .frame_count_o (frame_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive pix_ce_i for one clock and sample 1 time unit after the edge.
  task automatic step(input logic ce);
    pix_ce_i = ce;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    step(1'b1);
    step(1'b1);
    total++; if ({screen_x_o, screen_y_o} !== 20'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", screen_x_o, screen_y_o); end
    total++; if ({hsync_o, vsync_o} !== 2'b11) begin bad++; $display("FAIL reset_sync got=%b%b exp=11", hsync_o, vsync_o); end
    total++; if ({de_o, line_start_o, frame_start_o} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b%b%b exp=000", de_o, line_start_o, frame_start_o); end
    total++; if (frame_count_o !== 16'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", frame_count_o); end
  endtask

  // First line after release: origin strobes, de edge at 15/16, hsync window.
  task automatic test_first_line;
    int hs_low;
    int hs_first;
    hs_low   = 0;
    hs_first = -1;
    reset_i  = 1'b0;
    step(1'b1);
    total++; if ({screen_x_o, screen_y_o} !== 20'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d exp=0,0", screen_x_o, screen_y_o); end
    total++; if ({de_o, line_start_o, frame_start_o} !== 3'b111) begin bad++; $display("FAIL first_strobes got=%b%b%b exp=111", de_o, line_start_o, frame_start_o); end
    for (int i = 1; i < 25; i++) begin
      step(1'b1);
      if (hsync_o === 1'b0) begin
        if (hs_first < 0) hs_first = int'(screen_x_o);
        hs_low++;
      end
      if (i == 1) begin
        total++; if ({line_start_o, frame_start_o} !== 2'b00) begin bad++; $display("FAIL strobe_width got=%b%b exp=00", line_start_o, frame_start_o); end
      end
      if (i == 15) begin
        total++; if ({screen_x_o, de_o} !== {10'd15, 1'b1}) begin bad++; $display("FAIL de_last_active got x=%0d de=%b exp x=15 de=1", screen_x_o, de_o); end
      end
      if (i == 16) begin
        total++; if ({screen_x_o, de_o} !== {10'd16, 1'b0}) begin bad++; $display("FAIL de_first_blank got x=%0d de=%b exp x=16 de=0", screen_x_o, de_o); end
      end
    end
    total++; if (hs_first !== 18) begin bad++; $display("FAIL hsync_start got=%0d exp=18", hs_first); end
    total++; if (hs_low !== 4) begin bad++; $display("FAIL hsync_width got=%0d exp=4", hs_low); end
  endtask

  // Rest of frame 1: position sweep, de/line_start decode, vsync window.
  task automatic test_frame_sweep;
    int vs_low;
    int vs_fx;
    int vs_fy;
    int ex;
    int ey;
    int errs;
    vs_low = 0;
    vs_fx  = -1;
    vs_fy  = -1;
    errs   = 0;
    for (int i = 25; i < 375; i++) begin
      step(1'b1);
      ex = i % 25;
      ey = i / 25;
      if (vsync_o === 1'b0) begin
        if (vs_fx < 0) begin vs_fx = int'(screen_x_o); vs_fy = int'(screen_y_o); end
        vs_low++;
      end
      if ((int'(screen_x_o) != ex) || (int'(screen_y_o) != ey) ||
          (de_o !== ((ex < 16) && (ey < 8))) || (line_start_o !== (ex == 0)) ||
          (frame_start_o !== 1'b0)) begin
        errs++;
        if (errs <= 4) $display("FAIL sweep_pos got=%0d,%0d de=%b ls=%b fs=%b exp=%0d,%0d", screen_x_o, screen_y_o, de_o, line_start_o, frame_start_o, ex, ey);
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL sweep_errors got=%0d exp=0", errs); end
    total++; if ((vs_fx !== 0) || (vs_fy !== 10)) begin bad++; $display("FAIL vsync_start got=%0d,%0d exp=0,10", vs_fx, vs_fy); end
    total++; if (vs_low !== 50) begin bad++; $display("FAIL vsync_width got=%0d exp=50", vs_low); end
  endtask

  // Frame starts 2..4 and 16-bit wrap of the frame counter.
  task automatic test_frame_count;
    for (int f = 1; f <= 3; f++) begin
      step(1'b1);
      total++; if ({screen_x_o, screen_y_o, frame_start_o} !== 21'd1) begin bad++; $display("FAIL frame_start_%0d got=%0d,%0d fs=%b exp=0,0 fs=1", f, screen_x_o, screen_y_o, frame_start_o); end
      total++; if (frame_count_o !== (FC_EN ? 16'(f) : 16'd0)) begin bad++; $display("FAIL frame_count_%0d got=%0d exp=%0d", f, frame_count_o, FC_EN ? f : 0); end
      if (f < 3) for (int i = 1; i < 375; i++) step(1'b1);
    end
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    for (int i = 1; i < 375; i++) step(1'b1);
    step(1'b1);
    total++; if ({frame_start_o, frame_count_o} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL frame_count_wrap got fs=%b fc=%h exp fs=1 fc=0000", frame_start_o, frame_count_o); end
`endif
  endtask

  // Alternating enable: hold on disabled cycles, strobes never stretch.
  task automatic test_ce_toggle;
    step(1'b0);
    total++; if ({screen_x_o, line_start_o, frame_start_o} !== 12'd0) begin bad++; $display("FAIL ce_hold_strobe got x=%0d ls=%b fs=%b exp x=0 ls=0 fs=0", screen_x_o, line_start_o, frame_start_o); end
    for (int k = 1; k < 25; k++) begin
      step(1'b1);
      total++; if (int'(screen_x_o) !== k) begin bad++; $display("FAIL ce_adv got=%0d exp=%0d", screen_x_o, k); end
      step(1'b0);
      total++; if (int'(screen_x_o) !== k) begin bad++; $display("FAIL ce_hold got=%0d exp=%0d", screen_x_o, k); end
    end
    step(1'b1);
    total++; if ({screen_x_o, screen_y_o, line_start_o} !== {10'd0, 10'd1, 1'b1}) begin bad++; $display("FAIL ce_line_start got=%0d,%0d ls=%b exp=0,1 ls=1", screen_x_o, screen_y_o, line_start_o); end
    step(1'b0);
    total++; if (line_start_o !== 1'b0) begin bad++; $display("FAIL ce_line_clear got=%b exp=0", line_start_o); end
  endtask

  // Reset mid-frame at counter (10,5), then restart from the origin.
  task automatic test_reset_midframe;
    for (int i = 26; i <= 134; i++) step(1'b1);
    total++; if ({screen_x_o, screen_y_o} !== {10'd9, 10'd5}) begin bad++; $display("FAIL mid_position got=%0d,%0d exp=9,5", screen_x_o, screen_y_o); end
    reset_i = 1'b1;
    step(1'b1);
    total++; if ({screen_x_o, screen_y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o, frame_count_o} !== {20'd0, 2'b11, 3'b000, 16'd0}) begin
      bad++; $display("FAIL mid_reset got=%0d,%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d exp reset values", screen_x_o, screen_y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o, frame_count_o);
    end
    reset_i = 1'b0;
    step(1'b1);
    total++; if ({screen_x_o, screen_y_o, de_o, line_start_o, frame_start_o} !== {20'd0, 3'b111}) begin
      bad++; $display("FAIL mid_restart got=%0d,%0d de=%b ls=%b fs=%b exp=0,0 111", screen_x_o, screen_y_o, de_o, line_start_o, frame_start_o);
    end
    step(1'b1);
    total++; if ({screen_x_o, frame_start_o} !== {10'd1, 1'b0}) begin bad++; $display("FAIL mid_next got x=%0d fs=%b exp x=1 fs=0", screen_x_o, frame_start_o); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_i  = 1'b1;
    pix_ce_i = 1'b0;
    test_reset();
    test_first_line();
    test_frame_sweep();
    test_frame_count();
    test_ce_toggle();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
